// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter for a single memory port
//
// Shares one memory request/response port between the instruction fetch unit
// (read-only) and the load/store unit (read/write). One transaction is in
// flight at a time; requests are arbitrated round-robin under contention and
// a response that never arrives is turned into an error after TIMEOUT cycles.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ifu_req_*/ifu_addr  IFU read request channel (valid/ready)
//   ifu_resp_*          IFU response channel: rdata, err
//   lsu_req_*/lsu_*     LSU request channel: addr, wen, wdata, wmask
//   lsu_resp_*          LSU response channel: rdata (0 for writes), err
//   mem_req_*/mem_*     memory request channel with latched fields
//   mem_resp_*          memory response channel
//   owner               00 none, 01 IFU, 10 LSU

module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   input  logic              ifu_resp_ready,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic              ifu_resp_err,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wmask,
   output logic              lsu_resp_valid,
   input  logic              lsu_resp_ready,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_resp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic              mem_resp_valid,
   output logic              mem_resp_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_IFU  = 2'b01;
   localparam logic [1:0] OWN_LSU  = 2'b10;

   state_t             state, state_nx;
   logic               last_grant;   // 1 = LSU was granted last
   logic [1:0]         owner_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               wen_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [7:0]         wmask_q;
   logic [DATA_W-1:0]  rdata_q;
   logic               err_q;
   logic               late_q;       // a timed-out response is still owed by memory
   logic [CNT_W-1:0]   cnt;
   logic               timeout_hit;
   logic               ifu_grant;
   logic               lsu_grant;
   logic               resp_hs;

   // TIMEOUT = 0 disables the limit; the counter then simply wraps unused.
   assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

   // Grants are gated by rst so every ready output is 0 while reset is held.
   always_comb begin
      ifu_grant = 1'b0;
      lsu_grant = 1'b0;
      if (state == S_IDLE && rst) begin
         if (ifu_req_valid && lsu_req_valid) begin
            ifu_grant = last_grant;
            lsu_grant = !last_grant;
         end else begin
            ifu_grant = ifu_req_valid;
            lsu_grant = lsu_req_valid;
         end
      end
   end

   assign resp_hs = ((owner_q == OWN_IFU) && ifu_resp_ready) ||
                    ((owner_q == OWN_LSU) && lsu_resp_ready);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (ifu_grant || lsu_grant) state_nx = S_REQ;
         S_REQ:   if (mem_req_ready) state_nx = S_WAIT;
         // A response in the timeout cycle wins over the timeout.
         S_WAIT:  if (mem_resp_valid || timeout_hit) state_nx = S_RESP;
         S_RESP:  if (resp_hs) state_nx = late_q ? S_DRAIN : S_IDLE;
         S_DRAIN: if (mem_resp_valid) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      mem_req_valid  = (state == S_REQ);
      mem_resp_ready = (state == S_WAIT) || (state == S_DRAIN);
      ifu_req_ready  = ifu_grant;
      lsu_req_ready  = lsu_grant;
      ifu_resp_valid = (state == S_RESP) && (owner_q == OWN_IFU);
      lsu_resp_valid = (state == S_RESP) && (owner_q == OWN_LSU);
      ifu_rdata      = (owner_q == OWN_IFU) ? rdata_q : '0;
      lsu_rdata      = (owner_q == OWN_LSU) ? rdata_q : '0;
      ifu_resp_err   = (owner_q == OWN_IFU) && err_q;
      lsu_resp_err   = (owner_q == OWN_LSU) && err_q;
   end

   assign mem_addr  = addr_q;
   assign mem_wen   = wen_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign owner     = owner_q;

   // Transaction datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= 1'b1;
         owner_q    <= OWN_NONE;
         addr_q     <= '0;
         wen_q      <= 1'b0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         late_q     <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ifu_grant) begin
                  addr_q     <= ifu_addr;
                  wen_q      <= 1'b0;
                  wdata_q    <= '0;
                  wmask_q    <= '0;
                  owner_q    <= OWN_IFU;
                  last_grant <= 1'b0;
               end else if (lsu_grant) begin
                  addr_q     <= lsu_addr;
                  wen_q      <= lsu_wen;
                  wdata_q    <= lsu_wdata;
                  wmask_q    <= lsu_wmask;
                  owner_q    <= OWN_LSU;
                  last_grant <= 1'b1;
               end
            end
            S_REQ: begin
               if (mem_req_ready) cnt <= '0;
            end
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               if (mem_resp_valid) begin
                  rdata_q <= wen_q ? '0 : mem_rdata;
                  err_q   <= 1'b0;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  late_q  <= 1'b1;
               end
            end
            S_RESP: begin
               if (resp_hs && !late_q) owner_q <= OWN_NONE;
            end
            S_DRAIN: begin
               if (mem_resp_valid) begin
                  late_q  <= 1'b0;
                  owner_q <= OWN_NONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter

module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
   logic [AW-1:0] ifu_addr;
   logic [DW-1:0] ifu_rdata;
   logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_wdata, lsu_rdata;
   logic [7:0]    lsu_wmask;
   logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [7:0]    mem_wmask;
   logic [1:0]    owner;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
      .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
      .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   typedef struct {
      bit          is_lsu;
      logic [31:0] addr;
      bit          wen;
      logic [31:0] wdata;
      logic [7:0]  wmask;
      int          gap;
      int          stall;
      int          delay;
      logic [31:0] data;
   } req_t;

   int   vectors = 0;
   int   miscompares = 0;
   req_t ifu_q[$];
   req_t lsu_q[$];
   req_t cur;
   int   grant_log[$];
   int   cyc = 0, hs_cyc = 0, widx = 0, stall_cnt = 0, ifu_gap = 0, lsu_gap = 0;
   bit   active = 0, mem_acc = 0, mem_out = 0, drain = 0, last_lsu = 1;
   logic [1:0] exp_owner = 2'b00;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic req_t mk(input bit is_lsu, input logic [31:0] addr, input bit wen,
                               input logic [31:0] wdata, input logic [7:0] wmask,
                               input int gap, input int stall, input int delay,
                               input logic [31:0] data);
      req_t r;
      r.is_lsu = is_lsu; r.addr = addr; r.wen = is_lsu ? wen : 1'b0;
      r.wdata = wdata; r.wmask = wmask; r.gap = gap; r.stall = stall;
      r.delay = delay; r.data = data;
      return r;
   endfunction

   // Memory responds `delay` cycles into the wait; no answer inside TO cycles is a timeout.
   function automatic int due_cyc();
      return hs_cyc + 2 + ((cur.delay < TO) ? cur.delay : TO - 1);
   endfunction

   function automatic logic [31:0] exp_rdata();
      if (cur.delay >= TO || cur.wen) return 32'h0;
      return cur.data;
   endfunction

   task automatic cycle();
      bit ifu_hs, lsu_hs, mreq_hs, mresp_hs, rsp_hs, in_resp;
      cyc++;
      @(negedge clk);
      ifu_hs = ifu_req_valid && ifu_req_ready;
      lsu_hs = lsu_req_valid && lsu_req_ready;
      if (active || drain) begin
         check("ifu_req_ready_busy", ifu_req_ready, 0);
         check("lsu_req_ready_busy", lsu_req_ready, 0);
      end else begin
         check("ifu_req_ready", ifu_req_ready, ifu_req_valid && (!lsu_req_valid || last_lsu));
         check("lsu_req_ready", lsu_req_ready, lsu_req_valid && (!ifu_req_valid || !last_lsu));
      end
      if (active && !mem_acc) begin
         check("mem_req_valid", mem_req_valid, 1);
         check("mem_addr", mem_addr, cur.addr);
         check("mem_wen", mem_wen, cur.wen);
         check("mem_wmask", mem_wmask, cur.is_lsu ? cur.wmask : 8'h00);
         if (cur.is_lsu) check("mem_wdata", mem_wdata, cur.wdata);
      end else begin
         check("mem_req_valid_off", mem_req_valid, 0);
      end
      in_resp = active && mem_acc && (cyc >= due_cyc());
      if (in_resp) begin
         check("ifu_resp_valid", ifu_resp_valid, !cur.is_lsu);
         check("lsu_resp_valid", lsu_resp_valid, cur.is_lsu);
         if (cur.is_lsu) begin
            check("lsu_rdata", lsu_rdata, exp_rdata());
            check("lsu_resp_err", lsu_resp_err, cur.delay >= TO);
         end else begin
            check("ifu_rdata", ifu_rdata, exp_rdata());
            check("ifu_resp_err", ifu_resp_err, cur.delay >= TO);
         end
      end else begin
         check("ifu_resp_valid_off", ifu_resp_valid, 0);
         check("lsu_resp_valid_off", lsu_resp_valid, 0);
      end
      if ((active && mem_acc && !in_resp) || drain)
         check("mem_resp_ready_on", mem_resp_ready, 1);
      else
         check("mem_resp_ready_off", mem_resp_ready, 0);
      if (!drain) check("owner", owner, exp_owner);
      mreq_hs  = mem_req_valid && mem_req_ready;
      mresp_hs = mem_resp_valid && mem_resp_ready;
      rsp_hs   = (ifu_resp_valid && ifu_resp_ready) || (lsu_resp_valid && lsu_resp_ready);

      @(posedge clk);
      #1;
      if (ifu_hs || lsu_hs) begin
         if (ifu_hs && ifu_q.size() > 0) begin
            cur = ifu_q.pop_front(); ifu_gap = 0;
         end else if (lsu_q.size() > 0) begin
            cur = lsu_q.pop_front(); lsu_gap = 0;
         end
         active = 1; mem_acc = 0;
         exp_owner = cur.is_lsu ? 2'b10 : 2'b01;
         last_lsu = cur.is_lsu;
         stall_cnt = cur.stall;
         grant_log.push_back(int'(cur.is_lsu));
      end
      if (mreq_hs) begin
         mem_acc = 1; mem_out = 1; widx = 0; hs_cyc = cyc;
      end else begin
         if (mem_req_valid && stall_cnt > 0) stall_cnt--;
         if (mem_out) begin
            if (mresp_hs) begin
               mem_out = 0;
               if (drain) begin drain = 0; exp_owner = 2'b00; end
            end else begin
               widx++;
            end
         end
      end
      if (rsp_hs) begin
         active = 0;
         if (cur.delay >= TO) drain = 1;
         else exp_owner = 2'b00;
      end
      ifu_req_valid = 0;
      if (ifu_q.size() > 0) begin
         if (ifu_gap < ifu_q[0].gap) ifu_gap++;
         else begin ifu_req_valid = 1; ifu_addr = ifu_q[0].addr; end
      end
      lsu_req_valid = 0;
      if (lsu_q.size() > 0) begin
         if (lsu_gap < lsu_q[0].gap) lsu_gap++;
         else begin
            lsu_req_valid = 1; lsu_addr = lsu_q[0].addr; lsu_wen = lsu_q[0].wen;
            lsu_wdata = lsu_q[0].wdata; lsu_wmask = lsu_q[0].wmask;
         end
      end
      mem_req_ready  = (stall_cnt == 0);
      mem_resp_valid = mem_out && (widx >= cur.delay);
      mem_rdata      = mem_resp_valid ? cur.data : $urandom();
      ifu_resp_ready = ($urandom_range(3) != 0);
      lsu_resp_ready = ($urandom_range(3) != 0);
   endtask

   task automatic run_until_idle(input int max, input string tag);
      int n = 0;
      while ((ifu_q.size() > 0 || lsu_q.size() > 0 || active || drain || mem_out) && n < max) begin
         cycle();
         n++;
      end
      check(tag, n < max, 1);
      cycle();
      cycle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
      lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
      lsu_resp_ready = 0; mem_req_ready = 1; mem_resp_valid = 0; mem_rdata = '0;

      repeat (3) @(posedge clk);
      #1;
      ifu_req_valid = 1; lsu_req_valid = 1;
      #1;
      check("rst_owner", owner, 2'b00);
      check("rst_ifu_req_ready", ifu_req_ready, 0);
      check("rst_lsu_req_ready", lsu_req_ready, 0);
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_mem_resp_ready", mem_resp_ready, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
      check("rst_rdata", {ifu_rdata, lsu_rdata}, 0);
      ifu_req_valid = 0; lsu_req_valid = 0;
      @(negedge clk);
      #1 rst = 1;

      // IFU fetch answered after two wait cycles
      ifu_q.push_back(mk(0, 32'h8000_0000, 0, 0, 0, 0, 0, 2, 32'h0000_0413));
      run_until_idle(100, "t_ifu_read_done");

      // LSU store: rdata must come back as 0
      lsu_q.push_back(mk(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 8'h0F, 0, 0, 1, 32'h1234_5678));
      run_until_idle(100, "t_lsu_store_done");

      // Continuous contention: strict alternation starting with IFU
      grant_log.delete();
      for (int i = 0; i < 2; i++) begin
         ifu_q.push_back(mk(0, 32'h8000_0100 + 4 * i, 0, 0, 0, 0, 0, 1, $urandom()));
         lsu_q.push_back(mk(1, 32'h8000_2000 + 4 * i, 0, 0, 8'hFF, 0, 0, 0, $urandom()));
      end
      run_until_idle(200, "t_contention_done");
      check("grant_count", grant_log.size(), 4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check($sformatf("grant_order_%0d", i), grant_log[i], i % 2);

      // Timeout, late response drained, then a normal fetch
      ifu_q.push_back(mk(0, 32'h8000_0200, 0, 0, 0, 0, 0, TO + 10, 32'hBAD0_BAD0));
      ifu_q.push_back(mk(0, 32'h8000_0204, 0, 0, 0, 0, 0, 1, 32'h0000_0013));
      run_until_idle(200, "t_timeout_done");

      // Memory stalls acceptance for 5 cycles; no timeout may accrue meanwhile
      lsu_q.push_back(mk(1, 32'h8000_3000, 0, 0, 8'h00, 0, 5, TO - 1, 32'hCAFE_F00D));
      run_until_idle(100, "t_stall_done");

      // Reset while waiting for memory
      ifu_q.push_back(mk(0, 32'h8000_0300, 0, 0, 0, 0, 0, 40, 32'h0));
      n = 0;
      while (!(mem_acc && cyc >= hs_cyc + 2) && n < 50) begin
         cycle();
         n++;
      end
      check("t_reach_wait", n < 50, 1);
      #2;
      rst = 0;
      ifu_req_valid = 1; lsu_req_valid = 1;
      #1;
      check("mid_rst_owner", owner, 2'b00);
      check("mid_rst_mem_req_valid", mem_req_valid, 0);
      check("mid_rst_mem_resp_ready", mem_resp_ready, 0);
      check("mid_rst_mem_addr", mem_addr, 0);
      check("mid_rst_req_ready", {ifu_req_ready, lsu_req_ready}, 0);
      check("mid_rst_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
      ifu_q.delete(); lsu_q.delete();
      active = 0; mem_acc = 0; mem_out = 0; drain = 0; last_lsu = 1; exp_owner = 2'b00;
      stall_cnt = 0; ifu_gap = 0; lsu_gap = 0;
      ifu_req_valid = 0; lsu_req_valid = 0; mem_resp_valid = 0; mem_req_ready = 1;
      @(negedge clk);
      #1 rst = 1;
      grant_log.delete();
      lsu_q.push_back(mk(1, 32'h8000_4000, 1, 32'h0BAD_CAFE, 8'h33, 0, 0, 0, $urandom()));
      ifu_q.push_back(mk(0, 32'h8000_0400, 0, 0, 0, 0, 0, 0, $urandom()));
      run_until_idle(100, "t_post_rst_done");
      check("post_rst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

      // Randomized traffic
      for (int i = 0; i < 60; i++) begin
         ifu_q.push_back(mk(0, $urandom(), 0, 0, 0, $urandom_range(0, 6),
                            $urandom_range(0, 3), $urandom_range(0, TO + 2), $urandom()));
         lsu_q.push_back(mk(1, $urandom(), 1'($urandom_range(0, 1)), $urandom(), 8'($urandom()),
                            $urandom_range(0, 6), $urandom_range(0, 3),
                            $urandom_range(0, TO + 2), $urandom()));
      end
      run_until_idle(20000, "t_random_done");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
